apb_waitstate_slave: RTL and testbench
======================================

Name: apb_waitstate_slave

Overview:
- APB responder (completer) for the 8-bit APB bus: byte-wide register memory with programmable wait states and error response on out-of-range addresses.
- Sits behind the APB master's select/enable decode, one instance per PSELx.
- Gives the master a responder that exercises the PREADY stall and PSLVERR paths.

Parameters:
- DEPTH, 64: number of byte locations; valid addresses 0..DEPTH-1, where DEPTH <= 256.
- WAIT_CYCLES, 2: wait states inserted in every access phase; 0 gives zero-wait transfers; range 0..15.

Ports:
- PCLK  in  1  bus clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  8  byte address.
- PWDATA  in  8  write data.
- PREADY  out  1  transfer completes in this cycle.
- PRDATA  out  8  read data; valid only when PREADY=1 and the transfer is a read.
- PSLVERR  out  1  error response; valid only when PREADY=1.

Behaviour:
- Reset (RST_N low, asynchronous):
  - FSM goes to IDLE; wait counter clears to 0.
  - Latched address, data, write flag and error flag clear.
  - All memory locations clear to 0x00.
  - PREADY=0, PRDATA=0x00, PSLVERR=0.
- Reset asserted mid-transfer aborts the transfer with no memory write.
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - On an edge with PSEL=1 and PENABLE=0 (setup phase), go to ACCESS.
  - On that edge, latch PADDR, PWRITE and PWDATA.
  - Latch err = (PADDR >= DEPTH).
  - Latch rdata = err ? 0x00 : mem[PADDR].
  - Clear cnt to 0.
  - PSEL=1 with PENABLE=1 while in IDLE is a protocol violation: ignore it and stay in IDLE.
- ACCESS, per edge:
  - PSEL=0: abort. Go to IDLE, no write, no response.
  - PSEL=1, PENABLE=1 and cnt < WAIT_CYCLES: cnt increments.
  - PSEL=1 and PENABLE=0: cnt holds.
  - PSEL=1, PENABLE=1 and cnt == WAIT_CYCLES (completion cycle): if latched write and !err, mem[addr] <= latched wdata. Then go to IDLE.
- Outputs (combinational from registered state):
  - PREADY = (state==ACCESS) & PENABLE & PSEL & (cnt==WAIT_CYCLES).
  - PSLVERR = PREADY & err.
  - PRDATA = (PREADY & !write) ? rdata : 0x00.
- Latency:
  - Access phase lasts WAIT_CYCLES+1 cycles.
  - Total transfer is WAIT_CYCLES+2 cycles including setup.
- Back-to-back transfers:
  - The cycle after completion is IDLE.
  - A new setup phase in that cycle (PSEL=1, PENABLE=0) is accepted normally, with no idle gap required.
- Read data is sampled at setup. A write to the same address completing earlier is visible, because writes commit before the next setup edge.
- Address/data changes during ACCESS are ignored; latched values are used.
- Error transfers:
  - Write: memory unchanged.
  - Read: PRDATA=0x00 with PSLVERR=1.
  - Same wait-state timing as a valid transfer.
- Address width rule: PADDR is compared as unsigned 8-bit against DEPTH. With DEPTH=256 no error ever occurs.

Test Plan:
- Reset, then read addr 0x05 (WAIT_CYCLES=2) -> PREADY low 2 access cycles, high on the 3rd; PRDATA=0x00; PSLVERR=0.
- Write 0xA5 to 0x10, then back-to-back read 0x10 -> each access phase 3 cycles, PREADY pulses once per transfer, read returns PRDATA=0xA5.
- Write 0x3C to 0x40 (DEPTH=64) -> PSLVERR=1 with PREADY; subsequent read 0x3F returns prior contents; read 0x40 gives PSLVERR=1, PRDATA=0x00.
- WAIT_CYCLES=0: write 0x11 to 0x01, read 0x01 -> PREADY=1 in first PENABLE cycle; read returns 0x11.
- Drop PSEL after one wait cycle of a write of 0x77 to 0x02 -> no PREADY, FSM in IDLE, later read 0x02 returns 0x00.
- Assert RST_N low mid-access of a write of 0x99 to 0x03 -> PREADY/PSLVERR/PRDATA go 0 immediately; read 0x03 after reset returns 0x00.

Source files
------------

// File: rtl/apb_waitstate_slave_if.sv
// APB (8-bit) bus bundle between a master and one PSELx completer.
// Clock and reset travel as plain ports beside this interface.
interface apb_waitstate_slave_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic       pready;
  logic [7:0] prdata;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_waitstate_slave.sv
// APB byte-memory completer: WAIT_CYCLES+1 access cycles per transfer, PSLVERR past DEPTH.
// Stalls the master through PREADY; dropping PSEL mid-access aborts with no side effect.
module apb_waitstate_slave #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  pclk_i,
  input  logic                  rst_n_i,
  apb_waitstate_slave_if.slave  apb
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_L = 9'(DEPTH);
  localparam logic [3:0] WAIT_L  = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          write_q, write_d;
  logic          err_q, err_d;
  logic [7:0]    mem_q [DEPTH];

  logic          mem_we;
  logic          req_err;
  logic          last_wait;

  // Compare in 9 bits so DEPTH=256 never flags an error.
  assign req_err   = ({1'b0, apb.paddr} >= DEPTH_L);
  assign last_wait = (cnt_q == WAIT_L);

  assign apb.pready  = (state_q == ACCESS) & apb.penable & apb.psel & last_wait;
  assign apb.pslverr = apb.pready & err_q;
  assign apb.prdata  = (apb.pready & ~write_q) ? rdata_q : 8'h00;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    write_d = write_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d = ACCESS;
          cnt_d   = 4'd0;
          addr_d  = apb.paddr[AW-1:0];
          wdata_d = apb.pwdata;
          write_d = apb.pwrite;
          err_d   = req_err;
          rdata_d = req_err ? 8'h00 : mem_q[apb.paddr[AW-1:0]];
        end
      end
      ACCESS: begin
        if (!apb.psel) begin
          state_d = IDLE;
        end else if (apb.penable) begin
          if (last_wait) begin
            mem_we  = write_q & ~err_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_waitstate_slave.sv
// Directed vector bench: one completer with 2 wait states / 64 bytes, one with 0 wait / 256 bytes.
module tb_apb_waitstate_slave;

  logic clk;
  logic rst_n;

  apb_waitstate_slave_if bus0();
  apb_waitstate_slave_if bus1();

  apb_waitstate_slave #(.DEPTH(64), .WAIT_CYCLES(2)) dut0 (
    .pclk_i  (clk),
    .rst_n_i (rst_n),
    .apb     (bus0)
  );

  apb_waitstate_slave #(.DEPTH(256), .WAIT_CYCLES(0)) dut1 (
    .pclk_i  (clk),
    .rst_n_i (rst_n),
    .apb     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         psel;
    bit         pen;
    bit         pw;
    logic [7:0] addr;
    logic [7:0] wdata;
    bit         rdy;
    logic [7:0] rdata;
    bit         err;
  } vec_t;

  vec_t q0[$];
  vec_t q1[$];
  int   checks = 0;
  int   passes = 0;

  function automatic vec_t mk(string n, bit s, bit e, bit w, logic [7:0] a, logic [7:0] d,
                              bit r, logic [7:0] rd, bit er);
    vec_t v;
    v.name = n; v.psel = s; v.pen = e; v.pw = w; v.addr = a; v.wdata = d;
    v.rdy = r; v.rdata = rd; v.err = er;
    return v;
  endfunction

  task automatic check(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %02h want %02h", n, act, exp);
  endtask

  task automatic push(input int which, input vec_t v);
    if (which == 0) q0.push_back(v);
    else            q1.push_back(v);
  endtask

  // Full transfer: setup, wait states, completion cycle.
  task automatic add_xfer(input int which, input string tag, input bit w, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] rd, input bit er);
    int nw;
    nw = (which == 0) ? 2 : 0;
    push(which, mk({tag, "_su"}, 1, 0, w, a, d, 0, 8'h00, 0));
    for (int i = 0; i < nw; i++)
      push(which, mk($sformatf("%s_w%0d", tag, i), 1, 1, w, a, d, 0, 8'h00, 0));
    push(which, mk({tag, "_done"}, 1, 1, w, a, d, 1, rd, er));
  endtask

  task automatic drive(input int which, input vec_t v);
    if (which == 0) begin
      bus0.psel = v.psel; bus0.penable = v.pen; bus0.pwrite = v.pw;
      bus0.paddr = v.addr; bus0.pwdata = v.wdata;
    end else begin
      bus1.psel = v.psel; bus1.penable = v.pen; bus1.pwrite = v.pw;
      bus1.paddr = v.addr; bus1.pwdata = v.wdata;
    end
  endtask

  task automatic compare(input int which, input vec_t v);
    logic       r, e;
    logic [7:0] d;
    if (which == 0) begin r = bus0.pready; e = bus0.pslverr; d = bus0.prdata; end
    else            begin r = bus1.pready; e = bus1.pslverr; d = bus1.prdata; end
    check({v.name, ".pready"},  {7'b0, r}, {7'b0, v.rdy});
    check({v.name, ".pslverr"}, {7'b0, e}, {7'b0, v.err});
    check({v.name, ".prdata"},  d, v.rdata);
  endtask

  task automatic run_vec(input int which, input vec_t v);
    @(posedge clk);
    #1;
    drive(which, v);
    @(negedge clk);
    compare(which, v);
  endtask

  task automatic run_queue(input int which);
    if (which == 0) begin
      foreach (q0[i]) run_vec(0, q0[i]);
      q0.delete();
    end else begin
      foreach (q1[i]) run_vec(1, q1[i]);
      q1.delete();
    end
    drive(which, mk("idle", 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0));
  endtask

  initial begin
    vec_t idle;
    idle  = mk("idle", 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    rst_n = 1'b0;
    drive(0, mk("rst", 1, 1, 0, 8'h05, 8'h00, 0, 8'h00, 0));
    drive(1, idle);
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare(0, mk("in_reset", 1, 1, 0, 8'h05, 8'h00, 0, 8'h00, 0));
    rst_n = 1'b1;
    drive(0, idle);

    // 2-wait / 64-byte completer
    push(0, idle);
    add_xfer(0, "rd05", 0, 8'h05, 8'h00, 8'h00, 0);
    add_xfer(0, "wr10", 1, 8'h10, 8'hA5, 8'h00, 0);
    // Back-to-back read; address/data wander during access and must be ignored.
    push(0, mk("rd10_su",   1, 0, 0, 8'h10, 8'h00, 0, 8'h00, 0));
    push(0, mk("rd10_w0",   1, 1, 0, 8'h00, 8'hFF, 0, 8'h00, 0));
    push(0, mk("rd10_w1",   1, 1, 1, 8'h41, 8'hFF, 0, 8'h00, 0));
    push(0, mk("rd10_done", 1, 1, 0, 8'h00, 8'hFF, 1, 8'hA5, 0));
    push(0, idle);
    add_xfer(0, "wr3f", 1, 8'h3F, 8'h5A, 8'h00, 0);
    add_xfer(0, "wr40", 1, 8'h40, 8'h3C, 8'h00, 1);
    add_xfer(0, "rd3f", 0, 8'h3F, 8'h00, 8'h5A, 0);
    add_xfer(0, "rd00", 0, 8'h00, 8'h00, 8'h00, 0);
    add_xfer(0, "rd40", 0, 8'h40, 8'h00, 8'h00, 1);
    // PENABLE high in IDLE is ignored; PENABLE low in ACCESS holds the wait count.
    push(0, mk("viol0",     1, 1, 0, 8'h3F, 8'h00, 0, 8'h00, 0));
    push(0, mk("viol1",     1, 1, 0, 8'h3F, 8'h00, 0, 8'h00, 0));
    push(0, mk("rdh_su",    1, 0, 0, 8'h3F, 8'h00, 0, 8'h00, 0));
    push(0, mk("rdh_w0",    1, 1, 0, 8'h3F, 8'h00, 0, 8'h00, 0));
    push(0, mk("rdh_hold",  1, 0, 0, 8'h3F, 8'h00, 0, 8'h00, 0));
    push(0, mk("rdh_w1",    1, 1, 0, 8'h3F, 8'h00, 0, 8'h00, 0));
    push(0, mk("rdh_done",  1, 1, 0, 8'h3F, 8'h00, 1, 8'h5A, 0));
    // Abort by dropping PSEL after one wait cycle.
    push(0, mk("wr02_su",   1, 0, 1, 8'h02, 8'h77, 0, 8'h00, 0));
    push(0, mk("wr02_w0",   1, 1, 1, 8'h02, 8'h77, 0, 8'h00, 0));
    push(0, mk("wr02_abort",0, 0, 1, 8'h02, 8'h77, 0, 8'h00, 0));
    add_xfer(0, "rd02", 0, 8'h02, 8'h00, 8'h00, 0);
    run_queue(0);

    // 0-wait / 256-byte completer
    push(1, idle);
    add_xfer(1, "z_wr01", 1, 8'h01, 8'h11, 8'h00, 0);
    add_xfer(1, "z_rd01", 0, 8'h01, 8'h00, 8'h11, 0);
    add_xfer(1, "z_wrff", 1, 8'hFF, 8'hC3, 8'h00, 0);
    add_xfer(1, "z_rdff", 0, 8'hFF, 8'h00, 8'hC3, 0);
    add_xfer(1, "z_rd00", 0, 8'h00, 8'h00, 8'h00, 0);
    run_queue(1);

    // Reset in the completion cycle of a write: outputs drop at once, nothing is written.
    run_vec(0, mk("wr03_su", 1, 0, 1, 8'h03, 8'h99, 0, 8'h00, 0));
    run_vec(0, mk("wr03_w0", 1, 1, 1, 8'h03, 8'h99, 0, 8'h00, 0));
    run_vec(0, mk("wr03_w1", 1, 1, 1, 8'h03, 8'h99, 0, 8'h00, 0));
    @(posedge clk);
    #1;
    drive(0, mk("wr03_done", 1, 1, 1, 8'h03, 8'h99, 0, 8'h00, 0));
    #1;
    check("wr03_pre_rst.pready", {7'b0, bus0.pready}, 8'h01);
    rst_n = 1'b0;
    #1;
    compare(0, mk("wr03_in_rst", 1, 1, 1, 8'h03, 8'h99, 0, 8'h00, 0));
    @(negedge clk);
    drive(0, idle);
    @(negedge clk);
    rst_n = 1'b1;
    add_xfer(0, "rd03_post", 0, 8'h03, 8'h00, 8'h00, 0);
    add_xfer(0, "rd10_post", 0, 8'h10, 8'h00, 8'h00, 0);
    add_xfer(0, "rd3f_post", 0, 8'h3F, 8'h00, 8'h00, 0);
    run_queue(0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
